// File: rtl/ram8_pkg.sv
// Shared types and constants for the RAM8 arbiter slice.
package ram8_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int ADDR_W        = 3;

  typedef struct packed {
    logic                     valid;
    logic                     write;
    logic [ADDR_W-1:0]        addr;
    logic [WIDTH_DEFAULT-1:0] wdata;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; prio names the requester that wins a tie.
module rr_arb2
  import ram8_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio;

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) gnt = prio ? 2'b10 : 2'b01;
    else              gnt = req;
  end

  // the loser of any grant gets priority next time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      prio <= 1'b0;
    else if (gnt[0]) prio <= 1'b1;
    else if (gnt[1]) prio <= 1'b0;
  end

endmodule

// File: rtl/ram8_arbiter.sv
// Shares one RAM8 between requesters A and B with round-robin arbitration
// and a registered one-cycle read response per requester.
module ram8_arbiter #(
  parameter int WIDTH  = ram8_pkg::WIDTH_DEFAULT,
  parameter int ADDR_W = ram8_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WIDTH-1:0]  a_wdata,
  output logic              a_ready,
  output logic              a_rvalid,
  output logic [WIDTH-1:0]  a_rdata,
  input  logic              b_valid,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [WIDTH-1:0]  b_wdata,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [WIDTH-1:0]  b_rdata,
  output logic [WIDTH-1:0]  ram_in,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [WIDTH-1:0]  ram_out
);
  import ram8_pkg::*;

  req_t       req_a;
  req_t       req_b;
  logic [1:0] gnt_raw;
  logic [1:0] gnt;

  assign req_a = '{valid: a_valid, write: a_write, addr: a_addr, wdata: a_wdata};
  assign req_b = '{valid: b_valid, write: b_write, addr: b_addr, wdata: b_wdata};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({req_b.valid, req_a.valid}),
    .gnt   (gnt_raw)
  );

  // no handshake may complete while reset is held
  assign gnt     = gnt_raw & {2{rst_n}};
  assign a_ready = gnt[0];
  assign b_ready = gnt[1];

  always_comb begin
    ram_address = '0;
    ram_in      = '0;
    ram_load    = 1'b0;
    if (gnt[0]) begin
      ram_address = req_a.addr;
      ram_in      = req_a.wdata;
      ram_load    = req_a.write;
    end else if (gnt[1]) begin
      ram_address = req_b.addr;
      ram_in      = req_b.wdata;
      ram_load    = req_b.write;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= gnt[0] & ~req_a.write;
      b_rvalid <= gnt[1] & ~req_b.write;
      if (gnt[0] && !req_a.write) a_rdata <= ram_out;
      if (gnt[1] && !req_b.write) b_rdata <= ram_out;
    end
  end

endmodule
